rr_arbiter16: RTL and testbench
===============================

RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 Parameter MAX_HOLD, default 0, maximum consecutive grant cycles per winner; 0 means unlimited hold.
REQ-002 I_CLK  input  1  single clock; all state updates on rising edge.
REQ-003 I_NRESET  input  1  reset, asynchronous, active-low.
REQ-004 I_ENABLE  input  1  arbitration enable; low forces release and blocks new grants.
REQ-005 I_REQ  input  16  request vector; bit n = requester n.
REQ-006 O_GRANT  output  16  registered grant vector, one-hot or zero; drives the downstream 16-to-4 encoder.
REQ-007 O_VALID  output  1  registered; high when O_GRANT is nonzero.

Function
REQ-008 The block SHALL hold internal state: mode (IDLE, GRANT), 4-bit priority pointer PTR, hold counter HCNT wide enough for MAX_HOLD.
REQ-009 O_GRANT SHALL always be zero or exactly one-hot; O_VALID SHALL equal OR-reduction of O_GRANT every cycle.
REQ-010 Selection SHALL be a circular search of I_REQ starting at bit PTR, ascending, wrapping 15->0; the first set bit wins.
REQ-011 IDLE: O_GRANT=0; if I_ENABLE=1 and I_REQ!=0 at an edge, the block SHALL enter GRANT with the selected winner on that edge (grant visible 1 cycle after request).
REQ-012 IDLE with I_ENABLE=0 or I_REQ=0 SHALL remain IDLE; PTR unchanged.
REQ-013 GRANT with winner g SHALL hold O_GRANT unchanged while I_ENABLE=1, I_REQ[g]=1, and (MAX_HOLD=0 or HCNT<MAX_HOLD).
REQ-014 Release SHALL occur on the edge where I_REQ[g]=0, or I_ENABLE=0, or MAX_HOLD!=0 and HCNT=MAX_HOLD.
REQ-015 On every release PTR SHALL be set to (g+1) mod 16.
REQ-016 On release with I_ENABLE=1 and I_REQ!=0, the next winner SHALL be selected in the same edge using the updated PTR (no idle bubble); requester g is eligible only if no other bit is set.
REQ-017 On release with I_ENABLE=0 or I_REQ=0, the block SHALL go to IDLE with O_GRANT=0.
REQ-018 HCNT SHALL load 1 on every new grant (including back-to-back re-grant of the same requester) and increment each held cycle, saturating at MAX_HOLD.
REQ-019 With MAX_HOLD=0, HCNT SHALL not affect behaviour.
REQ-020 Changes to I_REQ bits other than g during GRANT SHALL not affect O_GRANT until release.

Reset
REQ-021 I_NRESET=0 SHALL immediately, without waiting for a clock, force O_GRANT=16'h0000, O_VALID=0, PTR=0, HCNT=0, mode IDLE.
REQ-022 Reset asserted mid-grant SHALL drop the grant immediately; the first edge after deassertion SHALL arbitrate from PTR=0 per REQ-011.

Verification
REQ-023 Reset, I_ENABLE=1, I_REQ=16'h0001 -> next edge O_GRANT=16'h0001, O_VALID=1.
REQ-024 MAX_HOLD=0, I_REQ=16'h8001, bit 0 dropped after 3 grant cycles -> edge of drop O_GRANT=16'h8000, no cycle with O_VALID=0.
REQ-025 MAX_HOLD=2, I_REQ=16'h0006 constant -> O_GRANT sequence 0002,0002,0004,0004,0002,0002...
REQ-026 Wrap: winner 16'h8000 releases with I_REQ=16'h4001 -> next O_GRANT=16'h0001 (PTR wrapped to 0).
REQ-027 I_ENABLE driven low during grant of 16'h0010 -> next edge O_GRANT=0, O_VALID=0, PTR=5; re-enable with I_REQ=16'h0011 -> O_GRANT=16'h0001.
REQ-028 I_NRESET pulsed low between edges during grant -> O_GRANT=0 before next edge; after release, I_REQ=16'h0100 -> O_GRANT=16'h0100 one edge later.

Source files
------------

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot grant and optional per-winner hold limit.
// Grant appears one edge after request; release and re-arbitration happen on the same edge with no idle bubble.
module rr_arbiter16 #(
  parameter int MAX_HOLD = 0
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_ENABLE,
  input  logic [15:0] I_REQ,
  output logic [15:0] O_GRANT,
  output logic        O_VALID
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} mode_t;

  mode_t          r_mode;
  logic [3:0]     r_ptr;
  logic [3:0]     r_win;
  logic [HW-1:0]  r_hcnt;
  logic [15:0]    r_grant;
  logic           r_valid;

  mode_t          w_mode;
  logic [3:0]     w_ptr;
  logic [3:0]     w_win;
  logic [HW-1:0]  w_hcnt;
  logic [3:0]     w_base;
  logic [4:0]     w_pick;
  logic           w_at_limit;
  logic           w_release;
  logic [15:0]    w_grant;

  // Returns {found, index} of the first set bit at or after start, wrapping 15->0.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = start + 4'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While granting, the search base is already the post-release pointer (winner + 1),
  // which leaves the current winner last in line.
  assign w_base     = (r_mode == GRANT) ? (r_win + 4'd1) : r_ptr;
  assign w_pick     = rr_pick(I_REQ, w_base);
  assign w_at_limit = (MAX_HOLD != 0) && (r_hcnt >= HW'(MAX_HOLD));
  assign w_release  = !I_ENABLE || !I_REQ[r_win] || w_at_limit;

  always_comb begin
    w_mode = r_mode;
    w_ptr  = r_ptr;
    w_win  = r_win;
    w_hcnt = r_hcnt;
    case (r_mode)
      IDLE: begin
        if (I_ENABLE && w_pick[4]) begin
          w_mode = GRANT;
          w_win  = w_pick[3:0];
          w_hcnt = HW'(1);
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr = r_win + 4'd1;
          if (I_ENABLE && w_pick[4]) begin
            w_win  = w_pick[3:0];
            w_hcnt = HW'(1);
          end else begin
            w_mode = IDLE;
            w_hcnt = '0;
          end
        end else if (MAX_HOLD != 0) begin
          w_hcnt = r_hcnt + HW'(1);
        end
      end
      default: w_mode = IDLE;
    endcase
  end

  always_comb begin
    w_grant = 16'h0000;
    if (w_mode == GRANT) w_grant[w_win] = 1'b1;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_mode  <= IDLE;
      r_ptr   <= 4'd0;
      r_win   <= 4'd0;
      r_hcnt  <= '0;
      r_grant <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      r_mode  <= w_mode;
      r_ptr   <= w_ptr;
      r_win   <= w_win;
      r_hcnt  <= w_hcnt;
      r_grant <= w_grant;
      r_valid <= (w_mode == GRANT);
    end
  end

  assign O_GRANT = r_grant;
  assign O_VALID = r_valid;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Scoreboard bench for rr_arbiter16: unlimited-hold and MAX_HOLD=2 instances share stimulus
// and are compared against a queue-fed round-robin reference model.
module tb_rr_arbiter16;

  logic        I_CLK;
  logic        I_NRESET;
  logic        I_ENABLE;
  logic [15:0] I_REQ;
  logic [15:0] grant0, grant2;
  logic        valid0, valid2;

  rr_arbiter16 #(.MAX_HOLD(0)) dut0 (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE), .I_REQ(I_REQ),
    .O_GRANT(grant0), .O_VALID(valid0)
  );

  rr_arbiter16 #(.MAX_HOLD(2)) dut2 (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE), .I_REQ(I_REQ),
    .O_GRANT(grant2), .O_VALID(valid2)
  );

  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  logic [15:0] q0[$];
  logic [15:0] q2[$];

  // Reference model state per instance: holder (-1 = none), pointer, cycles held so far.
  int mg[2];
  int mp[2];
  int mc[2];
  int mh[2] = '{0, 2};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] req, input int start);
    for (int i = 0; i < 16; i++) begin
      if (req[(start + i) % 16]) return (start + i) % 16;
    end
    return -1;
  endfunction

  function automatic logic [15:0] onehot(input int g);
    logic [15:0] v;
    v = 16'h0000;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mg[k] = -1;
      mp[k] = 0;
      mc[k] = 0;
    end
  endtask

  task automatic model_edge(input logic en, input logic [15:0] req);
    bit rel;
    for (int k = 0; k < 2; k++) begin
      if (mg[k] < 0) begin
        if (en && req != 0) begin
          mg[k] = pick(req, mp[k]);
          mc[k] = 1;
        end
      end else begin
        rel = !en || !req[mg[k]] || (mh[k] != 0 && mc[k] >= mh[k]);
        if (rel) begin
          mp[k] = (mg[k] + 1) % 16;
          mg[k] = (en && req != 0) ? pick(req, mp[k]) : -1;
          mc[k] = 1;
        end else begin
          mc[k]++;
        end
      end
    end
    q0.push_back(onehot(mg[0]));
    q2.push_back(onehot(mg[1]));
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, move to the next falling edge.
  task automatic step(input logic en, input logic [15:0] req);
    I_ENABLE = en;
    I_REQ    = req;
    model_edge(en, req);
    @(negedge I_CLK);
  endtask

  // Reset pulse strictly between edges, then the following edge arbitrates from PTR=0.
  task automatic pulse(input logic en, input logic [15:0] req);
    I_ENABLE = en;
    I_REQ    = req;
    #1;
    q0.push_back(16'h0000);
    q2.push_back(16'h0000);
    model_reset();
    I_NRESET = 1'b0;
    #2;
    I_NRESET = 1'b1;
    model_edge(en, req);
    @(negedge I_CLK);
  endtask

  initial begin
    logic [15:0] e0, e2;
    wait (mon_en);
    forever begin
      @(posedge I_CLK or negedge I_NRESET);
      #1;
      if (q0.size() == 0 || q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event at %0t: no expected entry queued", $time);
      end else begin
        e0 = q0.pop_front();
        e2 = q2.pop_front();
        chk("grant_hold0", grant0, e0);
        chk("valid_hold0", {15'd0, valid0}, {15'd0, (e0 != 16'h0)});
        chk("grant_hold2", grant2, e2);
        chk("valid_hold2", {15'd0, valid2}, {15'd0, (e2 != 16'h0)});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] req;
    logic        en;
    I_NRESET = 1'b0;
    I_ENABLE = 1'b0;
    I_REQ    = 16'h0000;
    model_reset();
    #2;
    chk("reset_grant0", grant0, 16'h0000);
    chk("reset_valid0", {15'd0, valid0}, 16'h0000);
    chk("reset_grant2", grant2, 16'h0000);
    chk("reset_valid2", {15'd0, valid2}, 16'h0000);
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    mon_en = 1;

    // Single requester right after reset.
    step(1'b1, 16'h0001);
    step(1'b1, 16'h0000);

    // Drop of bit 0 hands over to bit 15 without a gap.
    pulse(1'b0, 16'h0000);
    repeat (3) step(1'b1, 16'h8001);
    repeat (2) step(1'b1, 16'h8000);
    step(1'b1, 16'h0000);

    // Hold-limit alternation between two steady requesters.
    pulse(1'b0, 16'h0000);
    repeat (8) step(1'b1, 16'h0006);
    step(1'b1, 16'h0000);

    // Pointer wraps from 15 to 0.
    pulse(1'b0, 16'h0000);
    step(1'b1, 16'h8000);
    step(1'b1, 16'h8000);
    step(1'b1, 16'h4001);
    step(1'b1, 16'h0000);

    // Disable mid-grant, then re-enable with a pointer of 5.
    pulse(1'b0, 16'h0000);
    step(1'b1, 16'h0010);
    step(1'b1, 16'h0010);
    step(1'b0, 16'h0010);
    step(1'b1, 16'h0011);
    step(1'b1, 16'h0000);

    // Asynchronous reset during a grant.
    pulse(1'b0, 16'h0000);
    step(1'b1, 16'h0020);
    step(1'b1, 16'h0020);
    pulse(1'b1, 16'h0100);
    step(1'b1, 16'h0000);

    // Random traffic: sticky request vectors so grants are held, with occasional disables and resets.
    req = 16'h0000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 3))
          0:       req = 16'h0000;
          1:       req = 16'(1) << $urandom_range(0, 15);
          2:       req = 16'($urandom) & 16'($urandom);
          default: req = 16'($urandom);
        endcase
      end
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 99) == 0) pulse(en, req);
      else                            step(en, req);
    end
    step(1'b0, 16'h0000);

    checks++;
    if (q0.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d/%0d entries left, expected 0", q0.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
